miriscv_lsu: RTL and testbench
==============================

# miriscv_lsu

Load-store unit for the miriscv core: the initiator side of the data memory interface served by the on-chip RAM. It takes load/store requests from the decode/execute stage, generates word address, byte enables and lane-replicated write data, and stalls the core for the RAM's one-cycle read latency. It then sign- or zero-extends the returned lane into the register-file write-back value. Misaligned and illegal-size accesses are flagged and never reach memory.

## Interface

- No parameters.
- clk_i  in  1  core clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- lsu_req_i  in  1  current instruction is a load or store; held stable while lsu_stall_req_o=1.
- lsu_we_i  in  1  1 = store, 0 = load.
- lsu_size_i  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only); other codes illegal.
- lsu_addr_i  in  32  byte address.
- lsu_data_i  in  32  store data (rs2), low bits significant.
- lsu_data_o  out  32  extended load result; valid in WAIT only, 0 otherwise.
- lsu_stall_req_o  out  1  core must hold PC/pipeline this cycle.
- lsu_err_o  out  1  misaligned or illegal-size access this cycle.
- data_req_o  out  1  memory request.
- data_we_o  out  1  memory write enable.
- data_be_o  out  4  byte enables.
- data_addr_o  out  32  word-aligned address {lsu_addr_i[31:2], 2'b00}.
- data_wdata_o  out  32  lane-replicated store data.
- data_rdata_i  in  32  memory read data, valid the cycle after an accepted read request.

## Operation

- FSM states: IDLE, WAIT. Reset state IDLE.
- Alignment: H/HU require addr[0]=0; W requires addr[1:0]=00; B/BU always aligned. Store with size 100/101 is illegal.
- IDLE, no lsu_req_i: all data_* outputs 0, stall 0, err 0.
- IDLE, lsu_req_i, illegal or misaligned: lsu_err_o=1 (combinational), data_req_o=0, stall 0, stay IDLE.
- IDLE, legal store: data_req_o=1, data_we_o=1, stall 0, stay IDLE; write lands in RAM at this cycle's edge.
- IDLE, legal load: data_req_o=1, data_we_o=0, stall 1; latch size and off=addr[1:0]; go WAIT.
- WAIT: data_req_o=0, stall 0, lsu_data_o driven from data_rdata_i with latched size/off; lsu_req_i ignored (same instruction); unconditionally go IDLE.
- Byte enables (loads and stores): B/BU 0001<<off; H/HU 0011<<off; W 1111.
- Write data: B {4{lsu_data_i[7:0]}}; H {2{lsu_data_i[15:0]}}; W lsu_data_i.
- Load extension: B sign-extend rdata[8*off+7:8*off]; BU zero-extend same byte; H sign-extend rdata[16*off[1]+15:16*off[1]]; HU zero-extend same half; W rdata unchanged.

## Timing

- Store: 1 cycle, no stall.
- Load: 2 cycles; cycle 0 request + stall, cycle 1 result combinationally on lsu_data_o; core writes back and advances at end of cycle 1.
- Back-to-back loads: 2 cycles each; load after store: no bubble.
- All data_* outputs and err/stall are combinational from inputs and state; lsu_data_o from data_rdata_i plus latched fields.
- Reset: while rst_i=1 all outputs 0 (data_req_o gated by reset, not only by state); state IDLE, latched size/off cleared.
- Reset asserted in WAIT: immediately IDLE, lsu_data_o=0, stall 0; pending read result discarded.
- Reset released: first cycle behaves as IDLE.

## Test plan

- SW 0xDEADBEEF to 0x100, then LW 0x100 -> store: req=1, we=1, be=1111, addr=0x100, 1 cycle no stall; load: stall 1 cycle, lsu_data_o=0xDEADBEEF in WAIT.
- SB 0x...AB to 0x103 -> be=1000, wdata=0xABABABAB, addr=0x100; SH 0x1234 to 0x102 -> be=1100, wdata=0x12341234.
- LB 0x103 with rdata 0x80FF1234 -> 0xFFFFFF80; LBU 0x101 -> 0x00000012; LH 0x102 -> 0xFFFF80FF; LHU 0x102 -> 0x000080FF.
- LW 0x102, LH 0x101, store size 100 -> lsu_err_o=1, data_req_o=0, stall 0, FSM stays IDLE.
- Three back-to-back LW -> stall pattern 1,0,1,0,1,0; req pattern 1,0,1,0,1,0; correct data each WAIT.
- rst_i asserted mid-WAIT with lsu_req_i=1 -> all outputs 0 during reset; after release, held LW is re-issued from IDLE (req=1, stall=1).

Source files
------------

// File: rtl/miriscv_lsu_if.sv
// Data memory bus between the load-store unit (master) and the on-chip RAM (slave).
interface miriscv_lsu_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    logic              data_req_o;
    logic              data_we_o;
    logic [BE_W-1:0]   data_be_o;
    logic [ADDR_W-1:0] data_addr_o;
    logic [DATA_W-1:0] data_wdata_o;
    logic [DATA_W-1:0] data_rdata_i;

    modport master (
        output data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        input  data_rdata_i
    );

    modport slave (
        input  data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o,
        output data_rdata_i
    );
endinterface

// File: rtl/miriscv_lsu.sv
// Load-store unit: address/byte-enable/write-data generation, one-cycle load stall,
// and sign/zero extension of the returned lane.
module miriscv_lsu (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                lsu_req_i,
    input  logic                lsu_we_i,
    input  logic [2:0]          lsu_size_i,
    input  logic [31:0]         lsu_addr_i,
    input  logic [31:0]         lsu_data_i,
    output logic [31:0]         lsu_data_o,
    output logic                lsu_stall_req_o,
    output logic                lsu_err_o,
    miriscv_lsu_if.master       data_bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = 4;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t          state;
    logic [2:0]      size_q;
    logic [1:0]      off_q;

    logic            aligned;
    logic            legal;
    logic            issue;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [XLEN-1:0] ext_data;

    // Size legality and natural alignment; sizes 100/101 exist for loads only.
    always_comb begin
        aligned = 1'b0;
        case (lsu_size_i)
            3'b000, 3'b100: aligned = 1'b1;
            3'b001, 3'b101: aligned = ~lsu_addr_i[0];
            3'b010:         aligned = (lsu_addr_i[1:0] == 2'b00);
            default:        aligned = 1'b0;
        endcase
        legal = aligned & ~(lsu_we_i & lsu_size_i[2]);
    end

    assign issue = ~rst_i & (state == ST_IDLE) & lsu_req_i & legal;

    // Byte lanes and replicated store data
    always_comb begin
        be    = 4'b1111;
        wdata = lsu_data_i;
        case (lsu_size_i[1:0])
            2'b00: begin
                be    = 4'(4'b0001 << lsu_addr_i[1:0]);
                wdata = {4{lsu_data_i[7:0]}};
            end
            2'b01: begin
                be    = 4'(4'b0011 << lsu_addr_i[1:0]);
                wdata = {2{lsu_data_i[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = lsu_data_i;
            end
        endcase
    end

    assign data_bus.data_req_o   = issue;
    assign data_bus.data_we_o    = issue & lsu_we_i;
    assign data_bus.data_be_o    = issue ? be : '0;
    assign data_bus.data_addr_o  = issue ? {lsu_addr_i[31:2], 2'b00} : '0;
    assign data_bus.data_wdata_o = issue ? wdata : '0;

    assign lsu_stall_req_o = issue & ~lsu_we_i;
    assign lsu_err_o       = ~rst_i & (state == ST_IDLE) & lsu_req_i & ~legal;

    // Extract the addressed lane using the fields latched at request time
    always_comb begin
        rd_byte  = 8'(data_bus.data_rdata_i >> {off_q, 3'b000});
        rd_half  = 16'(data_bus.data_rdata_i >> {off_q[1], 4'b0000});
        ext_data = data_bus.data_rdata_i;
        case (size_q)
            3'b000:  ext_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  ext_data = {24'h0, rd_byte};
            3'b001:  ext_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  ext_data = {16'h0, rd_half};
            default: ext_data = data_bus.data_rdata_i;
        endcase
    end

    assign lsu_data_o = (~rst_i & (state == ST_WAIT)) ? ext_data : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            size_q <= 3'b000;
            off_q  <= 2'b00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue && !lsu_we_i) begin
                        state  <= ST_WAIT;
                        size_q <= lsu_size_i;
                        off_q  <= lsu_addr_i[1:0];
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_miriscv_lsu.sv
// Directed bench for miriscv_lsu with a byte-enabled RAM model and a load-result scoreboard.
module tb_miriscv_lsu;
    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        lsu_req_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [2:0]  lsu_size_i = 3'b000;
    logic [31:0] lsu_addr_i = '0;
    logic [31:0] lsu_data_i = '0;
    logic [31:0] lsu_data_o;
    logic        lsu_stall_req_o;
    logic        lsu_err_o;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem [0:63];
    logic [31:0] rdata = '0;

    miriscv_lsu_if bus ();

    miriscv_lsu dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .lsu_req_i       (lsu_req_i),
        .lsu_we_i        (lsu_we_i),
        .lsu_size_i      (lsu_size_i),
        .lsu_addr_i      (lsu_addr_i),
        .lsu_data_i      (lsu_data_i),
        .lsu_data_o      (lsu_data_o),
        .lsu_stall_req_o (lsu_stall_req_o),
        .lsu_err_o       (lsu_err_o),
        .data_bus        (bus.master)
    );

    always #5 clk_i = ~clk_i;

    // RAM: byte-enabled writes, read data one cycle after the request
    assign bus.data_rdata_i = rdata;
    always @(posedge clk_i) begin
        if (bus.data_req_o) begin
            if (bus.data_we_o) begin
                for (int i = 0; i < 4; i++)
                    if (bus.data_be_o[i])
                        mem[bus.data_addr_o[7:2]][8*i +: 8] <= bus.data_wdata_o[8*i +: 8];
            end else begin
                rdata <= mem[bus.data_addr_o[7:2]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic req, input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk_i);
        #1;
        lsu_req_i  = req;
        lsu_we_i   = we;
        lsu_size_i = size;
        lsu_addr_i = addr;
        lsu_data_i = data;
        @(negedge clk_i);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " req"},   32'(bus.data_req_o), 32'h0);
        chk({tag, " we"},    32'(bus.data_we_o), 32'h0);
        chk({tag, " be"},    32'(bus.data_be_o), 32'h0);
        chk({tag, " addr"},  bus.data_addr_o, 32'h0);
        chk({tag, " wdata"}, bus.data_wdata_o, 32'h0);
        chk({tag, " stall"}, 32'(lsu_stall_req_o), 32'h0);
        chk({tag, " err"},   32'(lsu_err_o), 32'h0);
        chk({tag, " data"},  lsu_data_o, 32'h0);
    endtask

    task automatic do_store(input string tag, input logic [2:0] size, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] exp_be,
                            input logic [31:0] exp_wdata);
        drive(1'b1, 1'b1, size, addr, data);
        chk({tag, " req"},   32'(bus.data_req_o), 32'h1);
        chk({tag, " we"},    32'(bus.data_we_o), 32'h1);
        chk({tag, " be"},    32'(bus.data_be_o), 32'(exp_be));
        chk({tag, " addr"},  bus.data_addr_o, {addr[31:2], 2'b00});
        chk({tag, " wdata"}, bus.data_wdata_o, exp_wdata);
        chk({tag, " stall"}, 32'(lsu_stall_req_o), 32'h0);
        chk({tag, " err"},   32'(lsu_err_o), 32'h0);
    endtask

    task automatic issue_load(input string tag, input logic [2:0] size, input logic [31:0] addr,
                              input logic [3:0] exp_be, input logic [31:0] exp_data);
        drive(1'b1, 1'b0, size, addr, 32'h0);
        chk({tag, " req"},   32'(bus.data_req_o), 32'h1);
        chk({tag, " we"},    32'(bus.data_we_o), 32'h0);
        chk({tag, " be"},    32'(bus.data_be_o), 32'(exp_be));
        chk({tag, " addr"},  bus.data_addr_o, {addr[31:2], 2'b00});
        chk({tag, " stall"}, 32'(lsu_stall_req_o), 32'h1);
        chk({tag, " err"},   32'(lsu_err_o), 32'h0);
        exp_q.push_back(exp_data);
    endtask

    task automatic finish_load(input string tag);
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        chk({tag, " wait req"},   32'(bus.data_req_o), 32'h0);
        chk({tag, " wait stall"}, 32'(lsu_stall_req_o), 32'h0);
        if (exp_q.size() == 0) begin
            chk({tag, " scoreboard empty"}, 32'h1, 32'h0);
        end else begin
            chk({tag, " data"}, lsu_data_o, exp_q.pop_front());
        end
    endtask

    task automatic do_load(input string tag, input logic [2:0] size, input logic [31:0] addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_data);
        issue_load(tag, size, addr, exp_be, exp_data);
        finish_load(tag);
    endtask

    task automatic do_err(input string tag, input logic we, input logic [2:0] size,
                          input logic [31:0] addr);
        drive(1'b1, we, size, addr, 32'hCAFEF00D);
        chk({tag, " err"},   32'(lsu_err_o), 32'h1);
        chk({tag, " req"},   32'(bus.data_req_o), 32'h0);
        chk({tag, " stall"}, 32'(lsu_stall_req_o), 32'h0);
    endtask

    initial begin
        // Reset with a legal store presented: request must be gated
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_size_i = SZ_W;
        lsu_addr_i = 32'h100; lsu_data_i = 32'h55555555;
        @(negedge clk_i);
        chk_quiet("reset");
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        lsu_req_i = 1'b0;
        @(negedge clk_i);
        chk_quiet("idle");

        do_store("sw", SZ_W, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
        do_load ("lw", SZ_W, 32'h100, 4'b1111, 32'hDEADBEEF);

        do_store("sb", SZ_B, 32'h103, 32'h123456AB, 4'b1000, 32'hABABABAB);
        do_store("sh", SZ_H, 32'h102, 32'hFFFF1234, 4'b1100, 32'h12341234);
        do_load ("lw merged", SZ_W, 32'h100, 4'b1111, 32'h1234BEEF);

        do_store("sw2", SZ_W, 32'h100, 32'h80FF1234, 4'b1111, 32'h80FF1234);
        do_load ("lb",  SZ_B,  32'h103, 4'b1000, 32'hFFFFFF80);
        do_load ("lbu", SZ_BU, 32'h101, 4'b0010, 32'h00000012);
        do_load ("lh",  SZ_H,  32'h102, 4'b1100, 32'hFFFF80FF);
        do_load ("lhu", SZ_HU, 32'h102, 4'b1100, 32'h000080FF);
        do_load ("lh lo", SZ_H, 32'h100, 4'b0011, 32'h00001234);
        do_load ("lbu hi", SZ_BU, 32'h103, 4'b1000, 32'h00000080);

        // Faults: no memory access; the following store proves the FSM stayed IDLE
        do_err("lw mis", 1'b0, SZ_W, 32'h102);
        do_store("sb after err", SZ_B, 32'h108, 32'h000000C3, 4'b0001, 32'hC3C3C3C3);
        do_err("lh mis", 1'b0, SZ_H, 32'h101);
        do_err("st bu",  1'b1, SZ_BU, 32'h100);
        do_store("sw after err", SZ_W, 32'h10C, 32'h33333333, 4'b1111, 32'h33333333);

        do_store("sw104", SZ_W, 32'h104, 32'h11111111, 4'b1111, 32'h11111111);
        do_store("sw108", SZ_W, 32'h108, 32'h22222222, 4'b1111, 32'h22222222);
        do_load ("b2b0", SZ_W, 32'h104, 4'b1111, 32'h11111111);
        do_load ("b2b1", SZ_W, 32'h108, 4'b1111, 32'h22222222);
        do_load ("b2b2", SZ_W, 32'h10C, 4'b1111, 32'h33333333);

        // Reset while waiting on a load that stays requested
        issue_load("rst lw", SZ_W, 32'h100, 4'b1111, 32'h80FF1234);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk_quiet("rst in wait");
        exp_q.delete();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("reissue req",   32'(bus.data_req_o), 32'h1);
        chk("reissue stall", 32'(lsu_stall_req_o), 32'h1);
        exp_q.push_back(32'h80FF1234);
        finish_load("reissue");

        drive(1'b0, 1'b0, SZ_B, 32'h0, 32'h0);
        chk_quiet("final idle");
        chk("scoreboard drained", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
